// File: rtl/ssd_tgt_pkg.sv
// Shared types and constants for the SSD1306-style I2C target.
package ssd_tgt_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ADDR,
        ST_ADDR_ACK,
        ST_CTRL,
        ST_CTRL_ACK,
        ST_BYTE,
        ST_BYTE_ACK,
        ST_IGNORE
    } tgt_state_t;

    localparam int         CTRL_DC_BIT    = 6;
    localparam logic [7:0] OP_COL_WINDOW  = 8'h21;
    localparam logic [7:0] OP_PAGE_WINDOW = 8'h22;
    localparam logic [6:0] COL_MAX        = 7'd127;
    localparam logic [2:0] PAGE_MAX       = 3'd7;

    // Vertical addressing: page advances first, column advances when page wraps.
    function automatic logic [9:0] ptr_advance(
        input logic [6:0] col,
        input logic [2:0] page,
        input logic [6:0] col_lo,
        input logic [6:0] col_hi,
        input logic [2:0] page_lo,
        input logic [2:0] page_hi
    );
        logic [6:0] col_n;
        logic [2:0] page_n;
        col_n  = col;
        page_n = page + 3'd1;
        if (page == page_hi) begin
            page_n = page_lo;
            col_n  = (col == col_hi) ? col_lo : col + 7'd1;
        end
        return {col_n, page_n};
    endfunction

endpackage

// File: rtl/ssd_i2c_target_line_sync.sv
// SCL/SDA synchronizer followed by one edge register; all detect outputs are registered.
module i2c_line_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic srst,
    input  logic scl,
    input  logic sda,
    output logic scl_rise,
    output logic scl_fall,
    output logic start_det,
    output logic stop_det,
    output logic sda_s
);

    logic [1:0] line_in;
    logic [1:0] line_s;
    logic       scl_d_reg;
    logic       sda_d_reg;
    logic       scl_rise_reg;
    logic       scl_fall_reg;
    logic       start_reg;
    logic       stop_reg;

    assign line_in = {sda, scl};

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_line
            logic [SYNC_STAGES-1:0] chain_reg;
            // Shift the raw line through the synchronizer; idle bus level is high.
            always_ff @(posedge clk) begin
                if (srst) begin
                    chain_reg <= '1;
                end else begin
                    chain_reg <= {chain_reg[SYNC_STAGES-2:0], line_in[gi]};
                end
            end
            assign line_s[gi] = chain_reg[SYNC_STAGES-1];
        end
    endgenerate

    // Edge register plus registered edge/condition pulses; sda_s stays aligned with the pulses.
    always_ff @(posedge clk) begin
        if (srst) begin
            scl_d_reg    <= 1'b1;
            sda_d_reg    <= 1'b1;
            scl_rise_reg <= 1'b0;
            scl_fall_reg <= 1'b0;
            start_reg    <= 1'b0;
            stop_reg     <= 1'b0;
        end else begin
            scl_d_reg    <= line_s[0];
            sda_d_reg    <= line_s[1];
            scl_rise_reg <= line_s[0] & ~scl_d_reg;
            scl_fall_reg <= ~line_s[0] & scl_d_reg;
            start_reg    <= line_s[0] & scl_d_reg & sda_d_reg & ~line_s[1];
            stop_reg     <= line_s[0] & scl_d_reg & ~sda_d_reg & line_s[1];
        end
    end

    assign scl_rise  = scl_rise_reg;
    assign scl_fall  = scl_fall_reg;
    assign start_det = start_reg;
    assign stop_det  = stop_reg;
    assign sda_s     = sda_d_reg;

endmodule

// File: rtl/ssd_i2c_target.sv
// SSD1306-class I2C receive model: address/control/byte decode, ACK drive, pixel pointer.
// Optional feature: define SSD_TGT_WINDOW_EN for 0x21/0x22 column/page window commands.
module ssd_i2c_target
    import ssd_tgt_pkg::*;
#(
    parameter logic [7:0] ADDRESS     = 8'h78,
    parameter int         SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       SCL,
    input  logic       SDA_IN,
    output logic       SDA_OUT,
    output logic       busy,
    output logic       cmd_valid,
    output logic [7:0] cmd_byte,
    output logic       pix_we,
    output logic [9:0] pix_addr,
    output logic [7:0] pix_data,
    output logic       frame_done,
    output logic       NACK
);

    logic scl_rise, scl_fall, start_det, stop_det, sda_s;

    i2c_line_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
        .clk       (clk),
        .srst      (reset),
        .scl       (SCL),
        .sda       (SDA_IN),
        .scl_rise  (scl_rise),
        .scl_fall  (scl_fall),
        .start_det (start_det),
        .stop_det  (stop_det),
        .sda_s     (sda_s)
    );

    tgt_state_t state_reg, state_next;
    logic [2:0] bit_cnt_reg, bit_cnt_next;
    logic [6:0] shift_reg, shift_next;
    logic       ack_phase_reg, ack_phase_next;
    logic       mode_reg, mode_next;
    logic       sda_out_reg, sda_out_next;
    logic       busy_reg, busy_next;
    logic       nack_reg, nack_next;
    logic       wrote_reg, wrote_next;
    logic [6:0] col_reg, col_next;
    logic [2:0] page_reg, page_next;
    logic       cmd_valid_reg, cmd_valid_next;
    logic [7:0] cmd_byte_reg, cmd_byte_next;
    logic       pix_we_reg, pix_we_next;
    logic [9:0] pix_addr_reg, pix_addr_next;
    logic [7:0] pix_data_reg, pix_data_next;
    logic       frame_done_reg, frame_done_next;
    logic [7:0] byte_in;
    logic [6:0] col_lo, col_hi;
    logic [2:0] page_lo, page_hi;

    assign byte_in = {shift_reg, sda_s};

`ifdef SSD_TGT_WINDOW_EN
    logic [6:0] col_lo_reg, col_lo_next, col_hi_reg, col_hi_next;
    logic [2:0] page_lo_reg, page_lo_next, page_hi_reg, page_hi_next;
    logic [2:0] arg_reg, arg_next;   // 0 none, 1/2 column args, 3/4 page args

    // Window bound registers, full panel after reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            col_lo_reg  <= 7'd0;
            col_hi_reg  <= COL_MAX;
            page_lo_reg <= 3'd0;
            page_hi_reg <= PAGE_MAX;
            arg_reg     <= 3'd0;
        end else begin
            col_lo_reg  <= col_lo_next;
            col_hi_reg  <= col_hi_next;
            page_lo_reg <= page_lo_next;
            page_hi_reg <= page_hi_next;
            arg_reg     <= arg_next;
        end
    end

    // Track 0x21/0x22 opcodes and capture their two argument bytes.
    always_comb begin
        col_lo_next  = col_lo_reg;
        col_hi_next  = col_hi_reg;
        page_lo_next = page_lo_reg;
        page_hi_next = page_hi_reg;
        arg_next     = arg_reg;
        if (start_det) begin
            arg_next = 3'd0;
        end else if (cmd_valid_next) begin
            case (arg_reg)
                3'd1: begin col_lo_next  = byte_in[6:0]; arg_next = 3'd2; end
                3'd2: begin col_hi_next  = byte_in[6:0]; arg_next = 3'd0; end
                3'd3: begin page_lo_next = byte_in[2:0]; arg_next = 3'd4; end
                3'd4: begin page_hi_next = byte_in[2:0]; arg_next = 3'd0; end
                default: begin
                    if (byte_in == OP_COL_WINDOW) begin
                        arg_next = 3'd1;
                    end else if (byte_in == OP_PAGE_WINDOW) begin
                        arg_next = 3'd3;
                    end
                end
            endcase
        end
    end

    assign col_lo  = col_lo_reg;
    assign col_hi  = col_hi_reg;
    assign page_lo = page_lo_reg;
    assign page_hi = page_hi_reg;
`else
    assign col_lo  = 7'd0;
    assign col_hi  = COL_MAX;
    assign page_lo = 3'd0;
    assign page_hi = PAGE_MAX;
`endif

    // State and output registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg      <= ST_IDLE;
            bit_cnt_reg    <= 3'd0;
            shift_reg      <= 7'd0;
            ack_phase_reg  <= 1'b0;
            mode_reg       <= 1'b0;
            sda_out_reg    <= 1'b1;
            busy_reg       <= 1'b0;
            nack_reg       <= 1'b0;
            wrote_reg      <= 1'b0;
            col_reg        <= 7'd0;
            page_reg       <= 3'd0;
            cmd_valid_reg  <= 1'b0;
            cmd_byte_reg   <= 8'd0;
            pix_we_reg     <= 1'b0;
            pix_addr_reg   <= 10'd0;
            pix_data_reg   <= 8'd0;
            frame_done_reg <= 1'b0;
        end else begin
            state_reg      <= state_next;
            bit_cnt_reg    <= bit_cnt_next;
            shift_reg      <= shift_next;
            ack_phase_reg  <= ack_phase_next;
            mode_reg       <= mode_next;
            sda_out_reg    <= sda_out_next;
            busy_reg       <= busy_next;
            nack_reg       <= nack_next;
            wrote_reg      <= wrote_next;
            col_reg        <= col_next;
            page_reg       <= page_next;
            cmd_valid_reg  <= cmd_valid_next;
            cmd_byte_reg   <= cmd_byte_next;
            pix_we_reg     <= pix_we_next;
            pix_addr_reg   <= pix_addr_next;
            pix_data_reg   <= pix_data_next;
            frame_done_reg <= frame_done_next;
        end
    end

    // Next-state logic: START/STOP take priority over every state.
    always_comb begin
        state_next      = state_reg;
        bit_cnt_next    = bit_cnt_reg;
        shift_next      = shift_reg;
        ack_phase_next  = ack_phase_reg;
        mode_next       = mode_reg;
        sda_out_next    = sda_out_reg;
        busy_next       = busy_reg;
        nack_next       = nack_reg;
        wrote_next      = wrote_reg;
        col_next        = col_reg;
        page_next       = page_reg;
        cmd_valid_next  = 1'b0;
        cmd_byte_next   = cmd_byte_reg;
        pix_we_next     = 1'b0;
        pix_addr_next   = pix_addr_reg;
        pix_data_next   = pix_data_reg;
        frame_done_next = 1'b0;

        if (start_det) begin
            state_next     = ST_ADDR;
            bit_cnt_next   = 3'd0;
            ack_phase_next = 1'b0;
            sda_out_next   = 1'b1;
        end else if (stop_det) begin
            state_next      = ST_IDLE;
            ack_phase_next  = 1'b0;
            sda_out_next    = 1'b1;
            busy_next       = 1'b0;
            frame_done_next = wrote_reg;
            wrote_next      = 1'b0;
        end else begin
            case (state_reg)
                ST_ADDR, ST_CTRL, ST_BYTE: begin
                    if (scl_rise) begin
                        shift_next   = byte_in[6:0];
                        bit_cnt_next = bit_cnt_reg + 3'd1;
                        if (bit_cnt_reg == 3'd7) begin
                            if (state_reg == ST_ADDR) begin
                                if (byte_in == ADDRESS) begin
                                    state_next = ST_ADDR_ACK;
                                    busy_next  = 1'b1;
                                end else begin
                                    state_next = ST_IGNORE;
                                    nack_next  = 1'b1;
                                end
                            end else if (state_reg == ST_CTRL) begin
                                state_next = ST_CTRL_ACK;
                                mode_next  = byte_in[CTRL_DC_BIT];
                                if (byte_in[CTRL_DC_BIT]) begin
                                    col_next  = col_lo;
                                    page_next = page_lo;
                                end
                            end else begin
                                state_next = ST_BYTE_ACK;
                                if (mode_reg) begin
                                    pix_we_next           = 1'b1;
                                    pix_addr_next         = {col_reg, page_reg};
                                    pix_data_next         = byte_in;
                                    wrote_next            = 1'b1;
                                    {col_next, page_next} = ptr_advance(col_reg, page_reg,
                                                                        col_lo, col_hi,
                                                                        page_lo, page_hi);
                                end else begin
                                    cmd_valid_next = 1'b1;
                                    cmd_byte_next  = byte_in;
                                end
                            end
                        end
                    end
                end
                ST_ADDR_ACK, ST_CTRL_ACK, ST_BYTE_ACK: begin
                    // First SCL fall pulls SDA low, the next one releases it.
                    if (scl_fall) begin
                        if (!ack_phase_reg) begin
                            sda_out_next   = 1'b0;
                            ack_phase_next = 1'b1;
                        end else begin
                            sda_out_next   = 1'b1;
                            ack_phase_next = 1'b0;
                            bit_cnt_next   = 3'd0;
                            if (state_reg == ST_ADDR_ACK) begin
                                state_next = ST_CTRL;
                            end else begin
                                state_next = ST_BYTE;
                            end
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign SDA_OUT    = sda_out_reg;
    assign busy       = busy_reg;
    assign NACK       = nack_reg;
    assign cmd_valid  = cmd_valid_reg;
    assign cmd_byte   = cmd_byte_reg;
    assign pix_we     = pix_we_reg;
    assign pix_addr   = pix_addr_reg;
    assign pix_data   = pix_data_reg;
    assign frame_done = frame_done_reg;

endmodule
